// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge_pkg: bridge FSM state encoding, read-command bit position and read-timeout substitute byte
package spi_reg_bridge_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WRITE, ST_RD_WAIT, ST_RD_HOLD} state_e;
  localparam int CMD_RD_BIT = 7;
  localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;
endpackage

// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if: SPI_slave byte handshake (byte_received/received_data/data_needed/data_to_send) plus register bus (addr/wdata/wr/rd/rdata/rvalid); master=bridge, slave=SPI_slave+register block
interface spi_reg_bridge_if #(parameter int ADDR_W = 7) ();
  logic              byte_received;
  logic [7:0]        received_data;
  logic              data_needed;
  logic [7:0]        data_to_send;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_wr;
  logic              bus_rd;
  logic [7:0]        bus_rdata;
  logic              bus_rvalid;
  modport master (
    input  byte_received, received_data, data_needed, bus_rdata, bus_rvalid,
    output data_to_send, bus_addr, bus_wdata, bus_wr, bus_rd
  );
  modport slave (
    output byte_received, received_data, data_needed, bus_rdata, bus_rvalid,
    input  data_to_send, bus_addr, bus_wdata, bus_wr, bus_rd
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser (clk, async active-low rst_n, d_i -> q_o), both flops reset to RST_VAL
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= {2{RST_VAL}};
    else        sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI frame decoder (clk, rst_n, ssel_i, bus master modport, frame_active_o, rd_timeout_err_o) turning command+data bytes into auto-incrementing register reads/writes
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int         ADDR_W     = 7,
  parameter int         RD_TIMEOUT = 15,
  parameter logic [7:0] IDLE_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ssel_i,
  spi_reg_bridge_if.master  bus,
  output logic              frame_active_o,
  output logic              rd_timeout_err_o
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  state_e            state_q;
  logic              ssel_s;
  logic              ssel_prev_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [7:0]        dts_q;
  logic [7:0]        wdata_q;
  logic              wr_q;
  logic              rd_q;
  logic              active_q;
  logic              err_q;
  logic [TW-1:0]     timer_q;
  logic              unused_ok;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk, .rst_n, .d_i(ssel_i), .q_o(ssel_s));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ssel_prev_q <= 1'b1;
      addr_q      <= '0;
      bus_addr_q  <= '0;
      dts_q       <= IDLE_BYTE;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      ssel_prev_q <= ssel_s;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      if (ssel_s) begin
        state_q  <= ST_IDLE;
        dts_q    <= IDLE_BYTE;
        active_q <= 1'b0;
      end else if (ssel_prev_q) begin
        state_q  <= ST_CMD;
        dts_q    <= IDLE_BYTE;
        active_q <= 1'b1;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_CMD:
            if (bus.byte_received) begin
              addr_q <= bus.received_data[ADDR_W-1:0];
              if (bus.received_data[CMD_RD_BIT]) begin
                rd_q       <= 1'b1;
                bus_addr_q <= bus.received_data[ADDR_W-1:0];
                timer_q    <= '0;
                state_q    <= ST_RD_WAIT;
              end else begin
                state_q <= ST_WRITE;
              end
            end
          ST_WRITE:
            if (bus.byte_received) begin
              wr_q       <= 1'b1;
              bus_addr_q <= addr_q;
              wdata_q    <= bus.received_data;
              addr_q     <= addr_q + 1'b1;
            end
          ST_RD_WAIT:
            if (bus.bus_rvalid) begin
              dts_q   <= bus.bus_rdata;
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_RD_HOLD;
            end else if (timer_q == TW'(RD_TIMEOUT - 1)) begin
              dts_q   <= TIMEOUT_BYTE;
              err_q   <= 1'b1;
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_RD_HOLD;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          ST_RD_HOLD:
            if (bus.byte_received) begin
              rd_q       <= 1'b1;
              bus_addr_q <= addr_q;
              timer_q    <= '0;
              state_q    <= ST_RD_WAIT;
            end
          default: ;
        endcase
      end
    end
  end
  assign bus.data_to_send = dts_q;
  assign bus.bus_addr     = bus_addr_q;
  assign bus.bus_wdata    = wdata_q;
  assign bus.bus_wr       = wr_q;
  assign bus.bus_rd       = rd_q;
  assign frame_active_o   = active_q;
  assign rd_timeout_err_o = err_q;
  assign unused_ok        = bus.data_needed;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: self-checking bench for spi_reg_bridge using a frame vector table, directed corner cases and randomized frames against a frame-level model
module tb_spi_reg_bridge;
  localparam int         ADDR_W     = 7;
  localparam int         RD_TIMEOUT = 15;
  localparam int         GAP        = RD_TIMEOUT + 7;
  localparam logic [7:0] IDLE_BYTE  = 8'hA5;
  typedef struct {
    logic [7:0]      cmd;
    int              nd;
    logic [3:0][7:0] d;
    int              lat;
    int              e_nstb;
    logic [6:0]      e_last;
    logic [7:0]      e_dts;
    logic            e_err;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ssel = 1'b1;
  logic       frame_active;
  logic       rd_err;
  int         n_chk = 0;
  int         n_fail = 0;
  int         rsp_lat = 0;
  int         cyc = 0;
  int         inj_cyc = -1;
  int         cnt = 0;
  logic [7:0] inj_data = 8'h00;
  logic [7:0] rsp_data = 8'h00;
  logic       both_seen = 1'b0;
  logic [6:0]  rq[$];
  logic [14:0] wq[$];
  vec_t       vec [7];
  int         w0, r0;
  spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bif ();
  spi_reg_bridge #(.ADDR_W(ADDR_W), .RD_TIMEOUT(RD_TIMEOUT), .IDLE_BYTE(IDLE_BYTE)) dut (
    .clk(clk), .rst_n(rst_n), .ssel_i(ssel), .bus(bif),
    .frame_active_o(frame_active), .rd_timeout_err_o(rd_err)
  );
  always #5 clk = ~clk;
  // Register-bus responder (answers addr^0x5A after rsp_lat cycles, or never when 0) and strobe log
  always @(negedge clk) begin
    cyc++;
    bif.bus_rvalid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = rsp_data;
      end
    end
    if (cyc == inj_cyc) begin
      bif.bus_rvalid = 1'b1;
      bif.bus_rdata  = inj_data;
    end
    if (bif.bus_rd) begin
      rq.push_back(bif.bus_addr);
      if (rsp_lat > 0) begin
        cnt      = rsp_lat;
        rsp_data = {1'b0, bif.bus_addr} ^ 8'h5A;
      end
    end
    if (bif.bus_wr) wq.push_back({bif.bus_addr, bif.bus_wdata});
    if (bif.bus_wr && bif.bus_rd) both_seen = 1'b1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bif.byte_received = 1'b1;
    bif.received_data = b;
    bif.data_needed   = 1'b0;
    @(negedge clk);
    bif.byte_received = 1'b0;
    bif.data_needed   = 1'b1;
  endtask
  // One full frame checked against the frame model: reads hit cmd_addr+i and return addr^0x5A
  // when the response comes within RD_TIMEOUT-1 cycles of the strobe, else 0xFF and a sticky error.
  task automatic run_frame(input logic [7:0] cmd, input int nd, input logic [3:0][7:0] d, input int lat,
                           output int nstb, output logic [6:0] last_a, output logic [7:0] last_dts,
                           output logic last_err);
    int         fw0, fr0;
    logic [6:0] a;
    logic       ok;
    logic       e_err;
    rsp_lat = lat;
    fw0 = wq.size();
    fr0 = rq.size();
    ok = lat > 0 && lat < RD_TIMEOUT;
    e_err = cmd[7] && !ok;
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    check("frame_start_active", 32'(frame_active), 1);
    check("frame_start_err", 32'(rd_err), 0);
    send_byte(cmd);
    a = cmd[6:0];
    for (int i = 0; i <= nd; i++) begin
      if (i > 0) send_byte(d[i-1]);
      repeat (cmd[7] ? GAP : 3) @(negedge clk);
      check("frame_data_to_send", 32'(bif.data_to_send),
            32'(cmd[7] ? (ok ? {1'b0, a} ^ 8'h5A : 8'hFF) : IDLE_BYTE));
      a++;
    end
    last_dts = bif.data_to_send;
    last_err = rd_err;
    check("frame_err", 32'(rd_err), 32'(e_err));
    ssel = 1'b1;
    repeat (4) @(negedge clk);
    check("frame_end_active", 32'(frame_active), 0);
    check("frame_end_dts", 32'(bif.data_to_send), 32'(IDLE_BYTE));
    check("frame_end_err_sticky", 32'(rd_err), 32'(e_err));
    nstb = cmd[7] ? rq.size() - fr0 : wq.size() - fw0;
    check("frame_strobe_count", 32'(nstb), 32'(cmd[7] ? nd + 1 : nd));
    check("frame_other_strobes", 32'(cmd[7] ? wq.size() - fw0 : rq.size() - fr0), 0);
    last_a = 7'h00;
    for (int i = 0; i < nstb && i < 5; i++) begin
      if (cmd[7]) begin
        check("frame_rd_addr", 32'(rq[fr0+i]), 32'(7'(cmd[6:0] + i)));
        last_a = rq[fr0+i];
      end else begin
        check("frame_wr_addr_data", 32'(wq[fw0+i]), 32'({7'(cmd[6:0] + i), d[i]}));
        last_a = wq[fw0+i][14:8];
      end
    end
  endtask
  initial begin
    int              nstb;
    int              nd;
    int              lat;
    logic [6:0]      la;
    logic [7:0]      ld;
    logic [7:0]      c;
    logic [3:0][7:0] dd;
    logic            le;
    vec[0] = '{8'h10, 3, 32'h00332211, 2, 3, 7'h12, 8'hA5, 1'b0};
    vec[1] = '{8'hFF, 3, 32'h00C0FFEE, 2, 4, 7'h02, 8'h58, 1'b0};
    vec[2] = '{8'h85, 0, 32'h00000000, 0, 1, 7'h05, 8'hFF, 1'b1};
    vec[3] = '{8'h7F, 2, 32'h0000BBAA, 3, 2, 7'h00, 8'hA5, 1'b0};
    vec[4] = '{8'hB0, 1, 32'h00000000, RD_TIMEOUT - 1, 2, 7'h31, 8'h6B, 1'b0};
    vec[5] = '{8'hC1, 1, 32'h00000000, RD_TIMEOUT, 2, 7'h42, 8'hFF, 1'b1};
    vec[6] = '{8'h20, 0, 32'h00000000, 1, 0, 7'h00, 8'hA5, 1'b0};
    bif.byte_received = 1'b0;
    bif.received_data = 8'h00;
    bif.data_needed   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dts", 32'(bif.data_to_send), 32'(IDLE_BYTE));
    check("reset_addr", 32'(bif.bus_addr), 0);
    check("reset_wdata", 32'(bif.bus_wdata), 0);
    check("reset_wr", 32'(bif.bus_wr), 0);
    check("reset_rd", 32'(bif.bus_rd), 0);
    check("reset_active", 32'(frame_active), 0);
    check("reset_err", 32'(rd_err), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      run_frame(vec[i].cmd, vec[i].nd, vec[i].d, vec[i].lat, nstb, la, ld, le);
      check("vec_nstb", 32'(nstb), 32'(vec[i].e_nstb));
      if (vec[i].e_nstb > 0) check("vec_last_addr", 32'(la), 32'(vec[i].e_last));
      check("vec_dts", 32'(ld), 32'(vec[i].e_dts));
      check("vec_err", 32'(le), 32'(vec[i].e_err));
    end
    // Exact timeout timing and sticky error lifetime
    rsp_lat = 0;
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h85);
    check("to_rd_strobe", 32'(bif.bus_rd), 1);
    check("to_rd_addr", 32'(bif.bus_addr), 32'h05);
    repeat (RD_TIMEOUT - 1) @(negedge clk);
    check("to_before_dts", 32'(bif.data_to_send), 32'(IDLE_BYTE));
    check("to_before_err", 32'(rd_err), 0);
    @(negedge clk);
    check("to_at_dts", 32'(bif.data_to_send), 32'hFF);
    check("to_at_err", 32'(rd_err), 1);
    ssel = 1'b1;
    repeat (4) @(negedge clk);
    check("to_sticky", 32'(rd_err), 1);
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    check("to_cleared", 32'(rd_err), 0);
    ssel = 1'b1;
    repeat (4) @(negedge clk);
    // Abort during RD_WAIT with a late response
    r0 = rq.size();
    w0 = wq.size();
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h83);
    repeat (3) @(negedge clk);
    ssel = 1'b1;
    inj_data = 8'h77;
    inj_cyc = cyc + 3;
    repeat (GAP) @(negedge clk);
    check("abort_dts", 32'(bif.data_to_send), 32'(IDLE_BYTE));
    check("abort_active", 32'(frame_active), 0);
    check("abort_err", 32'(rd_err), 0);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    check("abort_rd_count", 32'(rq.size() - r0), 1);
    check("abort_wr_count", 32'(wq.size() - w0), 0);
    // Reset between data bytes 2 and 3 of a write, while the write strobe is high
    ssel = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h40);
    send_byte(8'h01);
    send_byte(8'h02);
    check("rst_pre_wr", 32'(bif.bus_wr), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_wr", 32'(bif.bus_wr), 0);
    check("rst_async_addr", 32'(bif.bus_addr), 0);
    check("rst_async_wdata", 32'(bif.bus_wdata), 0);
    check("rst_async_dts", 32'(bif.data_to_send), 32'(IDLE_BYTE));
    check("rst_async_active", 32'(frame_active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_reframe_active", 32'(frame_active), 1);
    w0 = wq.size();
    send_byte(8'h50);
    send_byte(8'h99);
    repeat (3) @(negedge clk);
    ssel = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_reframe_count", 32'(wq.size() - w0), 1);
    if (wq.size() > w0) check("rst_reframe_wr", 32'(wq[w0]), 32'({7'h50, 8'h99}));
    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      c   = 8'($urandom);
      nd  = $urandom_range(0, 4);
      dd  = $urandom;
      lat = $urandom_range(0, RD_TIMEOUT + 2);
      run_frame(c, nd, dd, lat, nstb, la, ld, le);
    end
    check("no_wr_rd_overlap", 32'(both_seen), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
